parking_gate_ctrl: RTL and testbench

Multi-lane car-park gate controller. It generalises the single entry/exit gate pair to N_ENTRY entry lanes and N_EXIT exit lanes, each with its own gate state machine and a timed open window. A single shared occupancy counter is bounded by a parameterised CAPACITY. The block sits between the lane vehicle sensors and the gate actuators and publishes occupancy, full and empty status to the display/billing logic.

---
 rtl/parking_gate_ctrl.sv | 156 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Multi-lane car-park gate controller: one gate FSM per lane, a shared
// occupancy counter bounded by CAPACITY, fixed-priority grant allocation.

// Per-lane gate FSM: CLOSED -> OPEN for OPEN_CYC cycles -> CLEAR until req drops.
module parking_gate_lane #(
  parameter int OPEN_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  output logic cand,
  output logic gate_open
);
  localparam int HOLD_W = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [1:0] {CLOSED, OPEN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                open_q, open_d;

  // Only a closed, requesting lane competes for a grant.
  assign cand      = (state_q == CLOSED) && req;
  assign gate_open = open_q;

  // State, hold counter and registered gate output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLOSED;
      hold_q  <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      open_q  <= open_d;
    end
  end

  // Next-state logic; the gate output follows the next state so it is a flop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      CLOSED: begin
        if (grant) begin
          state_d = OPEN;
          hold_d  = HOLD_W'(OPEN_CYC - 1);
        end
      end
      OPEN: begin
        if (hold_q == '0) state_d = CLEAR;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      CLEAR: begin
        // Vehicle must leave the sensor before the lane can be granted again.
        if (!req) state_d = CLOSED;
      end
      default: state_d = CLOSED;
    endcase
    open_d = (state_d == OPEN);
  end
endmodule

// Top: lane arrays plus shared occupancy and grant allocation.
module parking_gate_ctrl #(
  parameter int N_ENTRY  = 2,
  parameter int N_EXIT   = 2,
  parameter int CAPACITY = 50,
  parameter int CNT_W    = 6,
  parameter int OPEN_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic [N_EXIT-1:0]  exit_req,
  output logic [N_ENTRY-1:0] entry_open,
  output logic [N_EXIT-1:0]  exit_open,
  output logic [N_ENTRY-1:0] entry_wait,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty
);
  localparam int SUM_W = CNT_W + 1;

  logic [N_ENTRY-1:0] ent_cand, ent_gnt;
  logic [N_EXIT-1:0]  ex_cand, ex_gnt;
  logic [SUM_W-1:0]   avail, n_ent, n_ex;
  logic [CNT_W-1:0]   occ_q, occ_d;

  // Free slots come from the registered count only, so exits this cycle
  // do not open entry slots until the next cycle.
  assign avail = SUM_W'(CAPACITY) - {1'b0, occ_q};

  // Entry grants: lowest index first, at most avail of them.
  always_comb begin
    ent_gnt = '0;
    n_ent   = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (ent_cand[i] && (n_ent < avail)) begin
        ent_gnt[i] = 1'b1;
        n_ent      = n_ent + SUM_W'(1);
      end
    end
  end

  // Exit grants: lowest index first, at most occupancy of them.
  always_comb begin
    ex_gnt = '0;
    n_ex   = '0;
    for (int j = 0; j < N_EXIT; j++) begin
      if (ex_cand[j] && (n_ex < {1'b0, occ_q})) begin
        ex_gnt[j] = 1'b1;
        n_ex      = n_ex + SUM_W'(1);
      end
    end
  end

  // Occupancy update; grant limits keep the sum inside 0..CAPACITY.
  always_comb begin
    occ_d = CNT_W'({1'b0, occ_q} + n_ent - n_ex);
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy  = occ_q;
  assign full       = (occ_q == CNT_W'(CAPACITY));
  assign empty      = (occ_q == '0);
  assign entry_wait = ent_cand & ~ent_gnt;

  for (genvar i = 0; i < N_ENTRY; i++) begin : g_ent
    parking_gate_lane #(.OPEN_CYC(OPEN_CYC)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .req       (entry_req[i]),
      .grant     (ent_gnt[i]),
      .cand      (ent_cand[i]),
      .gate_open (entry_open[i])
    );
  end

  for (genvar j = 0; j < N_EXIT; j++) begin : g_ex
    parking_gate_lane #(.OPEN_CYC(OPEN_CYC)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .req       (exit_req[j]),
      .grant     (ex_gnt[j]),
      .cand      (ex_cand[j]),
      .gate_open (exit_open[j])
    );
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized scoreboard bench for parking_gate_ctrl against a lane-timeline model.
module tb_parking_gate_ctrl;
  localparam int NE  = 3;
  localparam int NX  = 2;
  localparam int CAP = 5;
  localparam int CW  = 3;
  localparam int OC  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] entry_req = '0;
  logic [NX-1:0] exit_req  = '0;
  logic [NE-1:0] entry_open, entry_wait;
  logic [NX-1:0] exit_open;
  logic [CW-1:0] occupancy;
  logic          full, empty;

  parking_gate_ctrl #(
    .N_ENTRY(NE), .N_EXIT(NX), .CAPACITY(CAP), .CNT_W(CW), .OPEN_CYC(OC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .entry_open (entry_open),
    .exit_open  (exit_open),
    .entry_wait (entry_wait),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NE-1:0] eo;
    logic [NE-1:0] ew;
    logic [NX-1:0] xo;
    int            occ;
    logic          fl;
    logic          em;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   max_occ = 0;

  // Model: each lane remembers how many open cycles remain and whether it
  // is waiting for its vehicle to leave the sensor.
  int m_occ;
  int e_left[NE];
  bit e_clr[NE];
  int x_left[NX];
  bit x_clr[NX];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_occ = 0;
    for (int i = 0; i < NE; i++) begin e_left[i] = 0; e_clr[i] = 0; end
    for (int j = 0; j < NX; j++) begin x_left[j] = 0; x_clr[j] = 0; end
  endfunction

  function automatic void grants(input logic [NE-1:0] er, input logic [NX-1:0] xr,
                                 output logic [NE-1:0] eg, output logic [NX-1:0] xg);
    int n;
    eg = '0;
    xg = '0;
    n  = 0;
    for (int i = 0; i < NE; i++)
      if (er[i] && e_left[i] == 0 && !e_clr[i] && n < CAP - m_occ) begin
        eg[i] = 1'b1; n++;
      end
    n = 0;
    for (int j = 0; j < NX; j++)
      if (xr[j] && x_left[j] == 0 && !x_clr[j] && n < m_occ) begin
        xg[j] = 1'b1; n++;
      end
  endfunction

  // Advance the model across one rising edge using the inputs seen there.
  function automatic void model_edge();
    logic [NE-1:0] eg;
    logic [NX-1:0] xg;
    grants(entry_req, exit_req, eg, xg);
    for (int i = 0; i < NE; i++) begin
      if (eg[i]) e_left[i] = OC;
      else if (e_left[i] > 0) begin
        e_left[i]--;
        if (e_left[i] == 0) e_clr[i] = 1;
      end else if (e_clr[i] && !entry_req[i]) e_clr[i] = 0;
    end
    for (int j = 0; j < NX; j++) begin
      if (xg[j]) x_left[j] = OC;
      else if (x_left[j] > 0) begin
        x_left[j]--;
        if (x_left[j] == 0) x_clr[j] = 1;
      end else if (x_clr[j] && !exit_req[j]) x_clr[j] = 0;
    end
    m_occ = m_occ + $countones(eg) - $countones(xg);
    if (m_occ > max_occ) max_occ = m_occ;
  endfunction

  function automatic void push_exp();
    exp_t          e;
    logic [NE-1:0] eg;
    logic [NX-1:0] xg;
    grants(entry_req, exit_req, eg, xg);
    for (int i = 0; i < NE; i++) begin
      e.eo[i] = (e_left[i] > 0);
      e.ew[i] = entry_req[i] && e_left[i] == 0 && !e_clr[i] && !eg[i];
    end
    for (int j = 0; j < NX; j++) e.xo[j] = (x_left[j] > 0);
    e.occ = m_occ;
    e.fl  = (m_occ == CAP);
    e.em  = (m_occ == 0);
    q.push_back(e);
  endfunction

  task automatic drive_random(input int cyc);
    int pe, px;
    pe = ((cyc / 80) % 2 == 0) ? 70 : 25;
    px = ((cyc / 80) % 2 == 0) ? 20 : 65;
    for (int i = 0; i < NE; i++) entry_req[i] = ($urandom_range(0, 99) < pe);
    for (int j = 0; j < NX; j++) exit_req[j]  = ($urandom_range(0, 99) < px);
  endtask

  task automatic cycle(input int cyc);
    @(posedge clk);
    model_edge();
    #2;
    drive_random(cyc);
    push_exp();
  endtask

  // Reset mid-cycle: outputs must clear asynchronously, then a held
  // request is granted on the first edge after release.
  task automatic reset_mid();
    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_entry_open", int'(entry_open), 0);
    chk("rst_exit_open",  int'(exit_open),  0);
    chk("rst_occupancy",  int'(occupancy),  0);
    chk("rst_empty",      int'(empty),      1);
    chk("rst_full",       int'(full),       0);
    model_reset();
    @(posedge clk);
    #2;
    rst       = 1'b0;
    entry_req = '1;
    exit_req  = '0;
    push_exp();
  endtask

  // Monitor: every mid-cycle sample is compared with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("entry_open", int'(entry_open), int'(e.eo));
        chk("entry_wait", int'(entry_wait), int'(e.ew));
        chk("exit_open",  int'(exit_open),  int'(e.xo));
        chk("occupancy",  int'(occupancy),  e.occ);
        chk("full",       int'(full),       int'(e.fl));
        chk("empty",      int'(empty),      int'(e.em));
      end
    end
  end

  initial begin
    model_reset();
    #3;
    chk("init_occupancy",  int'(occupancy),  0);
    chk("init_empty",      int'(empty),      1);
    chk("init_full",       int'(full),       0);
    chk("init_entry_open", int'(entry_open), 0);
    chk("init_exit_open",  int'(exit_open),  0);
    chk("init_entry_wait", int'(entry_wait), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive_random(0);
    push_exp();
    for (int c = 1; c < 3000; c++) begin
      if (m_occ > 0 && $urandom_range(0, 99) < 2) reset_mid();
      else cycle(c);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("reached_full",  int'(max_occ == CAP), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
